// File: rtl/irrigation_pkg.sv
// Shared state encoding and default timing constants for the irrigation sequencer.
package irrigation_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    COOLDOWN = 2'd2,
    FAULT    = 2'd3
  } state_e;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_RUN      = 2'd1;
  localparam logic [1:0] ST_COOLDOWN = 2'd2;
  localparam logic [1:0] ST_FAULT    = 2'd3;

  localparam int DEF_DEBOUNCE_TICKS = 4;
  localparam int DEF_MIN_RUN_TICKS  = 8;
  localparam int DEF_MAX_RUN_TICKS  = 60;
  localparam int DEF_COOLDOWN_TICKS = 16;
  localparam int DEF_CNT_W          = 8;

endpackage

// File: rtl/tick_debouncer.sv
// Tick-qualified debouncer: the filtered level follows raw only after raw has
// differed from it on DEBOUNCE_TICKS consecutive ticks.
module tick_debouncer #(
  parameter int   DEBOUNCE_TICKS = 4,
  parameter int   CNT_W          = 8,
  parameter logic RESET_VAL      = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic clear,
  input  logic raw,
  output logic filtered,
  output logic settle
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(DEBOUNCE_TICKS);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;

  assign cnt_inc = cnt + CNT_W'(1);

  // Pulses on the very tick where filtered is about to flip, so a consumer can
  // act in the same clock as the flip instead of one clock later.
  assign settle = !clear && tick && (raw != filtered) && (cnt_inc == LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      filtered <= RESET_VAL;
    end else if (clear) begin
      cnt      <= '0;
      filtered <= RESET_VAL;
    end else if (tick) begin
      if (raw == filtered) begin
        cnt <= '0;
      end else if (cnt_inc == LIMIT) begin
        cnt      <= '0;
        filtered <= raw;
      end else begin
        cnt <= cnt_inc;
      end
    end
  end

endmodule

// File: rtl/irrigation_sequencer.sv
// Registered irrigation controller: debounced soil sensing, bounded run time,
// post-run cooldown and fault lockout driving pump, dripper and refill valve.
module irrigation_sequencer
  import irrigation_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS,
  parameter int MIN_RUN_TICKS  = DEF_MIN_RUN_TICKS,
  parameter int MAX_RUN_TICKS  = DEF_MAX_RUN_TICKS,
  parameter int COOLDOWN_TICKS = DEF_COOLDOWN_TICKS,
  parameter int CNT_W          = DEF_CNT_W
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       tick,
  input  logic       conflicting_values,
  input  logic       low_water_level,
  input  logic       high_water_level,
  input  logic       earth_humidity,
  input  logic       splinker_mode_on,
  output logic       water_supply_valvule,
  output logic       splinker_bomb,
  output logic       dripper_valvule,
  output logic       alarm,
  output logic       run_timeout,
  output logic [1:0] state_code
);

  if (MAX_RUN_TICKS >= (2 ** CNT_W) || COOLDOWN_TICKS >= (2 ** CNT_W) ||
      DEBOUNCE_TICKS >= (2 ** CNT_W)) begin : g_bad_cnt_w
    $error("CNT_W too narrow for the configured tick limits");
  end

  localparam logic [CNT_W-1:0] MIN_C  = CNT_W'(MIN_RUN_TICKS);
  localparam logic [CNT_W-1:0] MAX_C  = CNT_W'(MAX_RUN_TICKS);
  localparam logic [CNT_W-1:0] COOL_C = CNT_W'(COOLDOWN_TICKS);

  logic [1:0]       state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
  logic             mode, mode_n;
  logic             timeout_n;
  logic             soil_f;
  logic             fault_clear;
  logic             unused_soil_settle;
  logic             unused_clear_level;

  assign cnt_inc    = cnt + CNT_W'(1);
  assign state_code = state;

  tick_debouncer #(
    .DEBOUNCE_TICKS(DEBOUNCE_TICKS),
    .CNT_W         (CNT_W),
    .RESET_VAL     (1'b1)
  ) u_soil_db (
    .clk     (clock),
    .rst_n   (reset_n),
    .tick    (tick),
    .clear   (1'b0),
    .raw     (earth_humidity),
    .filtered(soil_f),
    .settle  (unused_soil_settle)
  );

  // Counts clean ticks only while locked out; any conflict restarts the count.
  tick_debouncer #(
    .DEBOUNCE_TICKS(DEBOUNCE_TICKS),
    .CNT_W         (CNT_W),
    .RESET_VAL     (1'b0)
  ) u_fault_db (
    .clk     (clock),
    .rst_n   (reset_n),
    .tick    (tick),
    .clear   (conflicting_values || (state != ST_FAULT)),
    .raw     (1'b1),
    .filtered(unused_clear_level),
    .settle  (fault_clear)
  );

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    mode_n    = mode;
    timeout_n = run_timeout;
    if (conflicting_values) begin
      state_n = ST_FAULT;
      cnt_n   = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (tick && !soil_f && low_water_level) begin
            state_n   = ST_RUN;
            cnt_n     = '0;
            mode_n    = splinker_mode_on;
            timeout_n = 1'b0;
          end
        end
        ST_RUN: begin
          if (!low_water_level) begin
            state_n = ST_COOLDOWN;
            cnt_n   = '0;
          end else if (tick) begin
            if (cnt_inc == MAX_C) begin
              state_n   = ST_COOLDOWN;
              cnt_n     = '0;
              timeout_n = 1'b1;
            end else if (cnt_inc >= MIN_C && soil_f) begin
              state_n = ST_COOLDOWN;
              cnt_n   = '0;
            end else begin
              cnt_n = cnt_inc;
            end
          end
        end
        ST_COOLDOWN: begin
          if (tick) begin
            if (cnt_inc == COOL_C) begin
              state_n = ST_IDLE;
              cnt_n   = '0;
            end else begin
              cnt_n = cnt_inc;
            end
          end
        end
        ST_FAULT: begin
          if (fault_clear) begin
            state_n = ST_IDLE;
            cnt_n   = '0;
          end
        end
        default: begin
          state_n = ST_IDLE;
          cnt_n   = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they change on the same edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state                <= ST_IDLE;
      cnt                  <= '0;
      mode                 <= 1'b0;
      run_timeout          <= 1'b0;
      splinker_bomb        <= 1'b0;
      dripper_valvule      <= 1'b0;
      alarm                <= 1'b0;
      water_supply_valvule <= 1'b0;
    end else begin
      state                <= state_n;
      cnt                  <= cnt_n;
      mode                 <= mode_n;
      run_timeout          <= timeout_n;
      splinker_bomb        <= (state_n == ST_RUN) && mode_n;
      dripper_valvule      <= (state_n == ST_RUN) && !mode_n;
      alarm                <= (state_n == ST_FAULT);
      water_supply_valvule <= (state_n != ST_FAULT) && !high_water_level;
    end
  end

endmodule

// File: tb/tb_irrigation_sequencer.sv
// Directed bench for irrigation_sequencer with hand-computed output vectors.
module tb_irrigation_sequencer;

  logic       clock;
  logic       reset_n;
  logic       tick;
  logic       conflicting_values;
  logic       low_water_level;
  logic       high_water_level;
  logic       earth_humidity;
  logic       splinker_mode_on;
  logic       water_supply_valvule;
  logic       splinker_bomb;
  logic       dripper_valvule;
  logic       alarm;
  logic       run_timeout;
  logic [1:0] state_code;

  // {water, bomb, dripper, alarm, timeout, state[1:0]}
  logic [6:0] outs;
  logic [6:0] exp_q[$];

  int checks;
  int failures;

  assign outs = {water_supply_valvule, splinker_bomb, dripper_valvule,
                 alarm, run_timeout, state_code};

  irrigation_sequencer dut (
    .clock               (clock),
    .reset_n             (reset_n),
    .tick                (tick),
    .conflicting_values  (conflicting_values),
    .low_water_level     (low_water_level),
    .high_water_level    (high_water_level),
    .earth_humidity      (earth_humidity),
    .splinker_mode_on    (splinker_mode_on),
    .water_supply_valvule(water_supply_valvule),
    .splinker_bomb       (splinker_bomb),
    .dripper_valvule     (dripper_valvule),
    .alarm               (alarm),
    .run_timeout         (run_timeout),
    .state_code          (state_code)
  );

  // clock / reset block
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 'b%b expected 'b%b", tag, obs, exp);
    end
  endtask

  // driver tasks: inputs change only at negedge, outputs sampled there too
  task automatic cycle();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic tick_once(input logic conf_on_tick);
    repeat (3) cycle();
    tick               = 1'b1;
    conflicting_values = conf_on_tick;
    cycle();
    tick               = 1'b0;
    conflicting_values = 1'b0;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick_once(1'b0);
  endtask

  initial begin
    logic [6:0] exp_v;
    checks             = 0;
    failures           = 0;
    reset_n            = 1'b0;
    tick               = 1'b0;
    conflicting_values = 1'b0;
    low_water_level    = 1'b1;
    high_water_level   = 1'b1;
    earth_humidity     = 1'b0;
    splinker_mode_on   = 1'b1;
    repeat (2) @(negedge clock);
    check("reset_state", outs, 7'b0000000);
    reset_n = 1'b1;

    // dry soil needs 4 debounce ticks, then the next tick starts a sprinkler run
    ticks(4);
    check("debounce_hold_idle", outs, 7'b0000000);
    ticks(1);
    check("run_entry_sprinkler", outs, 7'b0100001);

    // soil turns moist at run tick 3; mode toggle mid-run must be ignored
    ticks(2);
    earth_humidity   = 1'b1;
    splinker_mode_on = 1'b0;
    for (int k = 3; k <= 7; k++) exp_q.push_back(7'b0100001);
    exp_q.push_back(7'b0000010);
    while (exp_q.size() > 0) begin
      ticks(1);
      exp_v = exp_q.pop_front();
      check("min_run_then_cool", outs, exp_v);
    end
    ticks(15);
    check("cooldown_tick15", outs, 7'b0000010);
    ticks(1);
    check("cooldown_to_idle", outs, 7'b0000000);

    // dry soil throughout a dripper run ends by timeout at tick 60
    earth_humidity = 1'b0;
    ticks(4);
    check("redebounce_idle", outs, 7'b0000000);
    ticks(1);
    check("run_entry_dripper", outs, 7'b0010001);
    ticks(59);
    check("run_tick59", outs, 7'b0010001);
    ticks(1);
    check("timeout_cooldown", outs, 7'b0000110);
    ticks(16);
    check("timeout_sticky_idle", outs, 7'b0000100);
    ticks(1);
    check("timeout_cleared_run", outs, 7'b0010001);

    // conflict pulse between ticks; lockout needs 4 consecutive clean ticks
    ticks(2);
    conflicting_values = 1'b1;
    cycle();
    conflicting_values = 1'b0;
    check("fault_entry", outs, 7'b0001011);
    ticks(2);
    tick_once(1'b1);
    ticks(3);
    check("fault_glitch_restart", outs, 7'b0001011);
    ticks(1);
    check("fault_exit", outs, 7'b0000000);

    // low water ends a run on the next clock, no tick required
    splinker_mode_on = 1'b1;
    ticks(1);
    check("run_entry_after_fault", outs, 7'b0100001);
    ticks(2);
    low_water_level = 1'b0;
    cycle();
    low_water_level = 1'b1;
    check("low_water_cool", outs, 7'b0000010);
    ticks(16);
    check("low_water_cool_done", outs, 7'b0000000);
    ticks(1);
    check("run_before_reset", outs, 7'b0100001);

    // asynchronous reset mid-run, no clock edge involved
    #1 reset_n = 1'b0;
    #1 check("async_reset_drop", outs, 7'b0000000);
    @(negedge clock);
    reset_n = 1'b1;
    ticks(1);
    check("no_restart_after_reset", outs, 7'b0000000);

    high_water_level = 1'b0;
    check("refill_not_yet", outs, 7'b0000000);
    cycle();
    check("refill_one_clock", outs, 7'b1000000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/irrigation_sequencer.md
Name: irrigation_sequencer

Overview:
- Timed, registered controller that sequences the sprinkler pump and dripper valve, and gates the water supply valve.
- Replaces the purely combinational irrigation enable path.
- Sits between the water-sensor checker / irrigation-mode selector and the output LEDs. Runs off the system clock, with a one-cycle `tick` enable taken from the clock-divisor chain.
- Adds soil-sensor debounce, minimum and maximum run times, post-run cooldown and fault lockout.

Parameters:
- DEBOUNCE_TICKS, 4, consecutive ticks an input must hold a new value before the filtered value changes.
- MIN_RUN_TICKS, 8, minimum irrigation ticks before moist soil may end a run.
- MAX_RUN_TICKS, 60, hard run limit in ticks. Reaching it sets `run_timeout`.
- COOLDOWN_TICKS, 16, ticks with all actuators off after any run.
- CNT_W, 8, tick counter width. Must hold max(MAX_RUN_TICKS, COOLDOWN_TICKS, DEBOUNCE_TICKS); elaboration error otherwise.

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- tick  in  1  one-cycle timing enable (divided clock, synchronous to `clock`)
- conflicting_values  in  1  water-sensor inconsistency from checker
- low_water_level  in  1  1 = reservoir above low mark
- high_water_level  in  1  1 = reservoir full
- earth_humidity  in  1  1 = soil moist (raw sensor)
- splinker_mode_on  in  1  1 = sprinkler mode requested, 0 = dripper mode
- water_supply_valvule  out  1  refill valve
- splinker_bomb  out  1  sprinkler pump
- dripper_valvule  out  1  drip valve
- alarm  out  1  fault indicator
- run_timeout  out  1  last run ended by MAX_RUN_TICKS
- state_code  out  2  current state, for the LED array

Behaviour:
- Clock and reset: single clock, asynchronous active-low reset. All outputs are registered.
- Reset values: state=IDLE (state_code=0), counter=0, filtered soil=1 (moist), fault-clear count=0, latched mode=0, all outputs 0.
- Debounce: filtered soil copies `earth_humidity` only after the raw value differs from the filtered value on DEBOUNCE_TICKS consecutive ticks. A matching sample resets the count. Non-tick cycles neither count nor reset.
- State encoding: IDLE=0, RUN=1, COOLDOWN=2, FAULT=3.
- Priority each cycle, any state, tick not required:
  - `conflicting_values`=1 → FAULT next cycle, outputs off, counter cleared.
  - Else, in RUN, `low_water_level`=0 → COOLDOWN next cycle.
- IDLE → RUN on a tick where filtered soil=0, `low_water_level`=1 and no conflict. On entry:
  - mode latched from `splinker_mode_on`;
  - counter cleared;
  - `run_timeout` cleared.
- RUN:
  - `splinker_bomb` = latched mode; `dripper_valvule` = !latched mode. Exactly one is 1.
  - A mode input change mid-run is ignored until the next run.
  - Counter increments per tick.
  - On a tick where counter+1 == MAX_RUN_TICKS → COOLDOWN and set `run_timeout` (sticky until next RUN entry).
  - Otherwise, on a tick where counter+1 >= MIN_RUN_TICKS and filtered soil=1 → COOLDOWN.
  - If both conditions hold on the same tick, timeout wins and `run_timeout` is set.
- COOLDOWN:
  - Actuators off.
  - Counter cleared on entry, increments per tick.
  - → IDLE on the tick where counter+1 == COOLDOWN_TICKS.
  - A dry soil reading during cooldown is ignored.
- FAULT:
  - alarm=1, both irrigation outputs off, `water_supply_valvule`=0.
  - Exits to IDLE only after `conflicting_values`=0 on DEBOUNCE_TICKS consecutive ticks. Any conflict resets that count.
- Water supply: outside FAULT, `water_supply_valvule` = registered !high_water_level. It is independent of the irrigation state, so refill may overlap RUN.
- Latency: one clock from qualifying input or tick to output change.
- Counters never wrap. Counts are bounded by the exit comparisons.
- Reset mid-run: all actuators drop asynchronously. On release the block starts in IDLE with soil filtered as moist, so no immediate restart.
- tick held high continuously is legal. The block then runs at clock rate, which is used for simulation speedup.

Decomposition:
- Shared package `irrigation_pkg`:
  - state enum typedef (IDLE/RUN/COOLDOWN/FAULT, 2-bit);
  - default tick constants.
- One natural sub-module: `tick_debouncer` (parameterised DEBOUNCE_TICKS, CNT_W). Used twice: once for soil, once for fault-clear qualification.

Test Plan:
- Reset with earth_humidity=0, low=1, tick every 4 clocks → after 4 ticks of debounce, the next tick enters RUN. splinker_bomb=1 when splinker_mode_on=1; dripper stays 0.
- Mid-run soil → 1 at run tick 3 → run continues until tick 8 (MIN) plus debounce. No early exit; then COOLDOWN for 16 ticks, then IDLE.
- Soil stays dry → exit at tick 60, run_timeout=1, state_code=2. run_timeout stays 1 until the next RUN entry.
- conflicting_values pulse during RUN, mid-tick → next clock: alarm=1, all valves 0, state_code=3. Clears only after 4 clean ticks; a glitch at clean tick 3 restarts the count.
- low_water_level falls during RUN → COOLDOWN next clock. splinker_mode_on toggled mid-run → output unchanged.
- reset_n asserted mid-RUN without clock → all outputs 0 immediately. high_water_level=0 in IDLE → water_supply_valvule=1 one clock later.
